// File: rtl/coin_pulse_scheduler.sv
// Coin-slot pulse scheduler: synchronises two coin requests, queues them per slot and
// issues round-robin active-low pulses with a fixed gap. Optional COIN_TOTALS_EN adds issued-pulse totals.
module coin_pulse_scheduler #(
    parameter int unsigned TICK_DIV    = 12000,
    parameter int unsigned PULSE_TICKS = 50,
    parameter int unsigned GAP_TICKS   = 80,
    parameter int unsigned QUEUE_MAX   = 7
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [1:0]  coin_req,
    input  logic        hold,
    output logic [1:0]  coin_n,
    output logic        busy,
    output logic [3:0]  pending0,
    output logic [3:0]  pending1,
    output logic        drop
`ifdef COIN_TOTALS_EN
    ,
    output logic [15:0] total0,
    output logic [15:0] total1
`endif
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    PULSE_LAST = 8'(PULSE_TICKS - 1);
    localparam logic [7:0]    GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [3:0]    QMAX       = 4'(QUEUE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    sync1_q, sync2_q, sync3_q, edge_q;
    logic [3:0]    pend0_q, pend0_d, pend1_q, pend1_d;
    logic          drop_q, drop_d, drop0_s, drop1_s;
    logic          rr_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    tick_q;
    logic [1:0]    coin_n_q;
    logic          busy_q;
    logic          start_s, sel_s, both_s;
    logic [1:0]    deq_s;
    logic          presc_wrap_s, pulse_done_s, gap_done_s;

    // Returns {drop, next count}; a dequeue cancels a simultaneous edge, even when full.
    function automatic logic [4:0] queue_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [4:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt >= QMAX) begin
                res = {1'b1, cnt};
            end else begin
                res = {1'b0, cnt + 4'd1};
            end
        end else if (dec && !inc) begin
            res = {1'b0, cnt - 4'd1};
        end else begin
            res = {1'b0, cnt};
        end
        return res;
    endfunction

    // Two-flop synchroniser plus registered rising-edge detect; edges seen under hold are discarded.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            sync3_q <= 2'b00;
            edge_q  <= 2'b00;
        end else begin
            sync1_q <= coin_req;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= hold ? 2'b00 : (sync2_q & ~sync3_q);
        end
    end

    // Slot selection and timing terminal counts.
    always_comb begin
        start_s = 1'b0;
        sel_s   = 1'b0;
        both_s  = (pend0_q != 4'd0) && (pend1_q != 4'd0);
        if ((state_q == ST_IDLE) && !hold && ((pend0_q != 4'd0) || (pend1_q != 4'd0))) begin
            start_s = 1'b1;
            if (both_s) begin
                sel_s = rr_q;
            end else begin
                sel_s = (pend1_q != 4'd0);
            end
        end else begin
            start_s = 1'b0;
            sel_s   = 1'b0;
        end
        deq_s        = {start_s & sel_s, start_s & ~sel_s};
        presc_wrap_s = (presc_q == PRESC_LAST);
        pulse_done_s = presc_wrap_s && (tick_q == PULSE_LAST);
        gap_done_s   = presc_wrap_s && (tick_q == GAP_LAST);
    end

    // Queue next-state.
    always_comb begin
        {drop0_s, pend0_d} = queue_next(pend0_q, edge_q[0], deq_s[0]);
        {drop1_s, pend1_d} = queue_next(pend1_q, edge_q[1], deq_s[1]);
        drop_d             = drop0_s | drop1_s;
    end

    // Pending counters and drop strobe.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            pend0_q <= 4'd0;
            pend1_q <= 4'd0;
            drop_q  <= 1'b0;
        end else if (hold) begin
            pend0_q <= 4'd0;
            pend1_q <= 4'd0;
            drop_q  <= 1'b0;
        end else begin
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            drop_q  <= drop_d;
        end
    end

    // Pulse/gap sequencer; the timers restart on every state entry so durations are exact.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            presc_q  <= '0;
            tick_q   <= 8'd0;
            coin_n_q <= 2'b11;
            busy_q   <= 1'b0;
        end else if (hold) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            tick_q   <= 8'd0;
            coin_n_q <= 2'b11;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q  <= ST_PULSE;
                        rr_q     <= both_s ? ~rr_q : rr_q;
                        coin_n_q <= sel_s ? 2'b01 : 2'b10;
                        busy_q   <= 1'b1;
                        presc_q  <= '0;
                        tick_q   <= 8'd0;
                    end
                end
                ST_PULSE: begin
                    if (pulse_done_s) begin
                        state_q  <= ST_GAP;
                        coin_n_q <= 2'b11;
                        presc_q  <= '0;
                        tick_q   <= 8'd0;
                    end else if (presc_wrap_s) begin
                        presc_q <= '0;
                        tick_q  <= tick_q + 8'd1;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_done_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        presc_q <= '0;
                        tick_q  <= 8'd0;
                    end else if (presc_wrap_s) begin
                        presc_q <= '0;
                        tick_q  <= tick_q + 8'd1;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    coin_n_q <= 2'b11;
                    busy_q   <= 1'b0;
                    presc_q  <= '0;
                    tick_q   <= 8'd0;
                end
            endcase
        end
    end

`ifdef COIN_TOTALS_EN
    logic [15:0] tot0_q, tot1_q;

    // Issued-pulse totals survive hold; only RESET clears them.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            tot0_q <= 16'd0;
            tot1_q <= 16'd0;
        end else if (start_s) begin
            if (sel_s) begin
                tot1_q <= tot1_q + 16'd1;
            end else begin
                tot0_q <= tot0_q + 16'd1;
            end
        end
    end

    assign total0 = tot0_q;
    assign total1 = tot1_q;
`endif

    assign coin_n   = coin_n_q;
    assign busy     = busy_q;
    assign pending0 = pend0_q;
    assign pending1 = pend1_q;
    assign drop     = drop_q;

endmodule

// File: tb/tb_coin_pulse_scheduler.sv
// Directed and randomized bench for coin_pulse_scheduler, checked every cycle against
// a countdown-timer reference model of the scheduling rules.
module tb_coin_pulse_scheduler;

    localparam int TD = 4;
    localparam int PT = 3;
    localparam int GT = 2;
    localparam int QM = 3;
    localparam int PC = PT * TD;
    localparam int GC = GT * TD;

    logic        clk_sys  = 1'b0;
    logic        RESET    = 1'b1;
    logic        hold     = 1'b0;
    logic [1:0]  coin_req = 2'b00;
    logic [1:0]  coin_n;
    logic        busy;
    logic [3:0]  pending0, pending1;
    logic        drop;
`ifdef COIN_TOTALS_EN
    logic [15:0] total0, total1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int       m_phase, m_rem, m_slot, m_rr;
    int       m_p [2];
    int       m_tot [2];
    bit       m_drop, hold_prev;
    bit [1:0] hist [0:4];

    coin_pulse_scheduler #(
        .TICK_DIV(TD), .PULSE_TICKS(PT), .GAP_TICKS(GT), .QUEUE_MAX(QM)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .coin_req(coin_req), .hold(hold),
        .coin_n(coin_n), .busy(busy), .pending0(pending0), .pending1(pending1), .drop(drop)
`ifdef COIN_TOTALS_EN
        , .total0(total0), .total1(total1)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_rem = 0; m_slot = 0; m_rr = 0;
        m_p[0] = 0; m_p[1] = 0; m_tot[0] = 0; m_tot[1] = 0;
        m_drop = 1'b0; hold_prev = 1'b0;
        for (int k = 0; k < 5; k++) hist[k] = 2'b00;
    endtask

    // A request sampled at edge t is counted at edge t+3 and can launch a pulse at t+4.
    task automatic model_edge();
        bit [1:0] inc;
        bit [1:0] deq;
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = coin_req;
        inc = hist[3] & ~hist[4];
        if (hold_prev) inc = 2'b00;
        hold_prev = hold;
        m_drop = 1'b0;
        if (hold) begin
            m_phase = 0; m_rem = 0; m_p[0] = 0; m_p[1] = 0;
            return;
        end
        deq = 2'b00;
        if (m_phase == 0) begin
            if (m_p[0] > 0 || m_p[1] > 0) begin
                if (m_p[0] > 0 && m_p[1] > 0) begin
                    m_slot = m_rr;
                    m_rr = 1 - m_rr;
                end else begin
                    m_slot = (m_p[1] > 0) ? 1 : 0;
                end
                deq[m_slot] = 1'b1;
                m_phase = 1;
                m_rem = PC;
                m_tot[m_slot] = (m_tot[m_slot] + 1) % 65536;
            end
        end else if (m_phase == 1) begin
            m_rem--;
            if (m_rem == 0) begin m_phase = 2; m_rem = GC; end
        end else begin
            m_rem--;
            if (m_rem == 0) m_phase = 0;
        end
        for (int s = 0; s < 2; s++) begin
            if (inc[s] && !deq[s]) begin
                if (m_p[s] >= QM) m_drop = 1'b1;
                else m_p[s]++;
            end else if (deq[s] && !inc[s]) begin
                m_p[s]--;
            end
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_cn;
        exp_cn = (m_phase == 1) ? ((m_slot == 1) ? 2'b01 : 2'b10) : 2'b11;
        chk("coin_n", coin_n, exp_cn);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
        chk("pending0", pending0, m_p[0]);
        chk("pending1", pending1, m_p[1]);
        chk("drop", drop, m_drop);
`ifdef COIN_TOTALS_EN
        chk("total0", total0, m_tot[0]);
        chk("total1", total1, m_tot[1]);
`endif
    endtask

    task automatic step();
        @(posedge clk_sys);
        if (!RESET) model_edge();
        #1;
        compare_all();
    endtask

    task automatic next_pulse(output int slot, output int lo, output int gp);
        int w;
        w = 0; slot = 9; lo = 0; gp = 0;
        while (coin_n == 2'b11 && w < 300) begin step(); w++; end
        if (coin_n == 2'b10) slot = 0;
        else if (coin_n == 2'b01) slot = 1;
        while (coin_n != 2'b11 && lo < 300) begin lo++; step(); end
        while (busy && gp < 300) begin gp++; step(); end
    endtask

    initial begin
        int slot, lo, gp, lat, p3, nd, mx, cnt, pcyc;
        model_reset();
        step();
        step();
        chk("reset_coin_n", coin_n, 2'b11);
        RESET = 1'b0;
        step();

        // 1: single slot-1 edge, latency, widths
        coin_req = 2'b01;
        step();
        coin_req = 2'b00;
        lat = 0; p3 = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 3) p3 = pending0;
            if (coin_n[0] == 1'b0) begin lat = i; break; end
        end
        chk("t1_latency", lat, 4);
        chk("t1_pending_pre", p3, 1);
        lo = 0;
        while (coin_n[0] == 1'b0 && lo < 100) begin lo++; step(); end
        gp = 0;
        while (busy && gp < 100) begin gp++; step(); end
        chk("t1_low", lo, PC);
        chk("t1_busy", lo + gp, PC + GC);

        // 2: simultaneous requests, round-robin order
        step();
        coin_req = 2'b11;
        step();
        coin_req = 2'b00;
        next_pulse(slot, lo, gp);
        chk("t2_slot_a", slot, 0); chk("t2_low_a", lo, PC); chk("t2_gap_a", gp, GC);
        next_pulse(slot, lo, gp);
        chk("t2_slot_b", slot, 1); chk("t2_low_b", lo, PC); chk("t2_gap_b", gp, GC);
        coin_req = 2'b01;
        step();
        coin_req = 2'b00;
        next_pulse(slot, lo, gp);
        chk("t2_slot_c", slot, 0);

        // 3: saturate slot-2 queue during a slot-1 pulse
        coin_req = 2'b01;
        step();
        coin_req = 2'b00;
        cnt = 0;
        while (coin_n != 2'b10 && cnt < 20) begin cnt++; step(); end
        nd = 0; mx = 0;
        for (int i = 0; i < 14; i++) begin
            coin_req = (i < 10 && i % 2 == 0) ? 2'b10 : 2'b00;
            step();
            if (drop) nd++;
            if (pending1 > mx) mx = pending1;
        end
        chk("t3_drops", nd, 2);
        chk("t3_pend_max", mx, QM);
        for (int k = 0; k < 3; k++) begin
            next_pulse(slot, lo, gp);
            chk("t3_slot2_pulse", slot, 1);
        end
        cnt = 0;
        for (int i = 0; i < 60; i++) begin step(); if (busy) cnt++; end
        chk("t3_no_extra", cnt, 0);

        // 4: hold mid-pulse with two coins queued
        pcyc = 0;
        for (int i = 0; i < 30; i++) begin
            coin_req = (i < 6 && i % 2 == 0) ? 2'b01 : 2'b00;
            step();
            if (coin_n == 2'b10) pcyc++;
            if (pcyc == 6) break;
        end
        chk("t4_pend_before", pending0, 2);
        hold = 1'b1;
        step();
        chk("t4_coin_n", coin_n, 2'b11);
        chk("t4_pending0", pending0, 0);
        chk("t4_busy", busy, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            coin_req = (i == 1) ? 2'b11 : 2'b00;
            step();
            if (coin_n != 2'b11) cnt++;
        end
        hold = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); if (busy) cnt++; end
        chk("t4_hold_ignored", cnt, 0);

        // 5: asynchronous reset mid-gap with a coin queued
        for (int i = 0; i < 4; i++) begin
            coin_req = (i % 2 == 0) ? 2'b10 : 2'b00;
            step();
        end
        cnt = 0;
        while (!(busy && coin_n == 2'b11) && cnt < 60) begin cnt++; step(); end
        step();
        chk("t5_pend_gap", pending1, 1);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        chk("t5_async_coin_n", coin_n, 2'b11);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_pend1", pending1, 0);
        step();
        step();
        RESET = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin step(); if (busy) cnt++; end
        chk("t5_no_pulse", cnt, 0);

`ifdef COIN_TOTALS_EN
        // 6: total0 wraps
        force dut.tot0_q = 16'hFFFF;
        m_tot[0] = 65535;
        step();
        release dut.tot0_q;
        coin_req = 2'b01;
        step();
        coin_req = 2'b00;
        next_pulse(slot, lo, gp);
        chk("t6_total0_wrap", total0, 16'h0000);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) coin_req = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 199) == 0);
            step();
        end
        hold = 1'b0;
        coin_req = 2'b00;
        for (int i = 0; i < 300; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
